// File: rtl/vdiv_pkg.sv
// Shared types and real-valued helpers for the resistive-divider read path.
package vdiv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Reconstruct the divider source voltage from a converter code.
  function automatic real vdiv_backscale(input int unsigned code, input int nbits,
                                         input real vref, input real r1, input real r2);
    return real'(code) * vref / real'(2 ** nbits) * (r1 + r2) / r2;
  endfunction

  function automatic real vdiv_clamp(input real v, input real lo, input real hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/vdiv_sar_reader_sar_core.sv
// One successive-approximation conversion: load captures the held sample, then one
// bit is decided per cycle, MSB first. done/code are valid in the LSB decision cycle.
module sar_core
  import vdiv_pkg::*;
#(
  parameter int  NBITS = 10,
  parameter real VREF  = 5.0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  real              sh_i,
  output logic             done_o,
  output logic [NBITS-1:0] code_o
);

  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;

  real              sh_q;
  logic [NBITS-1:0] trial_q;
  logic [NBITS-1:0] trial_d;
  logic [NBITS-1:0] bit_mask;
  logic [NBITS-1:0] decided;
  logic [BW-1:0]    bit_q;
  logic             active_q;
  real              dac;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    bit_mask = {{(NBITS-1){1'b0}}, 1'b1} << bit_q;
    dac      = real'(trial_q) * VREF / real'(2 ** NBITS);
    decided  = (sh_q >= dac) ? trial_q : (trial_q & ~bit_mask);
    trial_d  = decided | (bit_mask >> 1);
  end

  assign done_o = active_q && (bit_q == '0);
  assign code_o = decided;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q     <= 0.0;
      trial_q  <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
    end else if (load_i) begin
      sh_q     <= sh_i;
      trial_q  <= {1'b1, {(NBITS-1){1'b0}}};
      bit_q    <= BW'(NBITS - 1);
      active_q <= 1'b1;
    end else if (active_q) begin
      trial_q <= trial_d;
      if (bit_q == '0) active_q <= 1'b0;
      else             bit_q    <= bit_q - BW'(1);
    end
  end

endmodule

// File: rtl/vdiv_sar_reader.sv
// Burst sequencer: runs 2**AVG_LOG2 SAR conversions of the divider tap, averages
// them, back-scales to the source voltage and presents the result on a valid/ready port.
module vdiv_sar_reader
  import vdiv_pkg::*;
#(
  parameter int  NBITS    = 10,
  parameter int  AVG_LOG2 = 2,
  parameter real VREF     = 5.0,
  parameter real R1       = 10_000.0,
  parameter real R2       = 10_000.0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  real              vtap,
  input  logic             start,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_code,
  output real              out_vsrc,
  output logic             out_clip
);

  localparam int ACC_W = NBITS + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int NAVG  = 1 << AVG_LOG2;

  state_e           state_q;
  logic             busy_q;
  logic             out_valid_q;
  logic [NBITS-1:0] out_code_q;
  real              out_vsrc_q;
  logic             out_clip_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             clip_q;

  logic             sar_load;
  real              sar_sh;
  logic             sar_done;
  logic [NBITS-1:0] sar_code;
  logic [CNT_W-1:0] cnt_inc;
  logic [NBITS-1:0] avg_code;

  always_comb begin
    sar_load = (state_q == SAMPLE);
    sar_sh   = vdiv_clamp(vtap, 0.0, VREF);
    cnt_inc  = cnt_q + CNT_W'(1);
    avg_code = acc_q[ACC_W-1:AVG_LOG2];
  end

  sar_core #(
    .NBITS (NBITS),
    .VREF  (VREF)
  ) u_sar (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (sar_load),
    .sh_i   (sar_sh),
    .done_o (sar_done),
    .code_o (sar_code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_vsrc_q  <= 0.0;
      out_clip_q  <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      clip_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SAMPLE;
            busy_q  <= 1'b1;
            acc_q   <= '0;
            cnt_q   <= '0;
            clip_q  <= 1'b0;
          end
        end
        SAMPLE: begin
          if (vtap < 0.0 || vtap > VREF) clip_q <= 1'b1;
          state_q <= CONVERT;
        end
        CONVERT: begin
          if (sar_done) begin
            acc_q   <= acc_q + ACC_W'(sar_code);
            cnt_q   <= cnt_inc;
            state_q <= (cnt_inc == CNT_W'(NAVG)) ? DONE : SAMPLE;
          end
        end
        DONE: begin
          // First DONE cycle publishes the result; later cycles wait for the consumer.
          if (!out_valid_q) begin
            out_code_q  <= avg_code;
            out_vsrc_q  <= vdiv_backscale(int'(avg_code), NBITS, VREF, R1, R2);
            out_clip_q  <= clip_q;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_vsrc  = out_vsrc_q;
  assign out_clip  = out_clip_q;

endmodule

// File: tb/tb_vdiv_sar_reader.sv
// Scoreboard bench for vdiv_sar_reader at default parameters.
module tb_vdiv_sar_reader;

  typedef struct {
    int  code;
    real vsrc;
    bit  clip;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  real        vtap = 0.0;
  logic       start = 1'b0;
  logic       busy;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [9:0] out_code;
  real        out_vsrc;
  logic       out_clip;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  vdiv_sar_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vtap      (vtap),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_vsrc  (out_vsrc),
    .out_clip  (out_clip)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_code(input real v);
    real c;
    int  k;
    c = (v < 0.0) ? 0.0 : ((v > 5.0) ? 5.0 : v);
    k = int'($floor(c * 1024.0 / 5.0));
    return (k > 1023) ? 1023 : k;
  endfunction

  task automatic push_exp(input real va, input real vb);
    exp_t e;
    int   sum;
    real  v;
    sum    = 0;
    e.clip = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v = (i % 2 == 0) ? va : vb;
      sum += model_code(v);
      if (v < 0.0 || v > 5.0) e.clip = 1'b1;
    end
    e.code = sum / 4;
    e.vsrc = real'(e.code) * 5.0 / 1024.0 * 2.0;
    sb.push_back(e);
  endtask

  task automatic start_burst(input real va, input real vb);
    push_exp(va, vb);
    vtap  = va;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  // Walks the burst from the accepting edge, driving the tap only for SAMPLE edges
  // and junk otherwise, then compares the result against the scoreboard head.
  task automatic wait_result(input real va, input real vb, input string tag);
    int   k;
    exp_t e;
    k = 0;
    while (k < 200) begin
      vtap  = (k % 11 == 0) ? (((k / 11) % 2 == 0) ? va : vb) : 7.0;
      start = (k == 5);
      @(posedge clk); #1;
      k++;
      if (out_valid) break;
    end
    start = 1'b0;
    check({tag, "_latency"}, k, 45);
    if (out_valid && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_code"}, out_code, e.code);
      check({tag, "_vsrc_nV"}, longint'(out_vsrc * 1e9), longint'(e.vsrc * 1e9));
      check({tag, "_clip"}, out_clip, e.clip);
      check({tag, "_busy_low"}, busy, 0);
    end
  endtask

  initial begin
    logic [9:0] held_code;
    longint     held_vsrc;
    logic       held_clip;

    #12;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_code", out_code, 0);
    check("rst_vsrc", longint'(out_vsrc * 1e9), 0);
    check("rst_clip", out_clip, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Mid-scale; a start pulse during conversion must not queue a second burst.
    start_burst(2.5, 2.5);
    wait_result(2.5, 2.5, "mid");
    repeat (2) @(posedge clk);
    #1;
    check("no_requeue_busy", busy, 0);
    check("no_requeue_valid", out_valid, 0);

    start_burst(1.0, 1.0);
    wait_result(1.0, 1.0, "one_volt");
    @(posedge clk); #1;

    start_burst(6.0, 6.0);
    wait_result(6.0, 6.0, "over");
    @(posedge clk); #1;

    start_burst(5.0, 5.0);
    wait_result(5.0, 5.0, "full_scale");
    @(posedge clk); #1;

    start_burst(-0.3, -0.3);
    wait_result(-0.3, -0.3, "under");
    @(posedge clk); #1;

    start_burst(1.0, 3.0);
    wait_result(1.0, 3.0, "alt");
    @(posedge clk); #1;

    // Back-pressure: result holds and starts are ignored until accepted.
    out_ready = 1'b0;
    start_burst(3.3, 3.3);
    wait_result(3.3, 3.3, "hold");
    held_code = out_code;
    held_vsrc = longint'(out_vsrc * 1e9);
    held_clip = out_clip;
    for (int i = 0; i < 10; i++) begin
      start = (i % 3 == 0);
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_busy", busy, 0);
      check("hold_code", out_code, held_code);
    end
    check("hold_vsrc", longint'(out_vsrc * 1e9), held_vsrc);
    check("hold_clip", out_clip, held_clip);
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    check("hs_valid_low", out_valid, 0);
    check("hs_start_ignored", busy, 0);
    check("hs_code_kept", out_code, held_code);
    push_exp(0.7, 0.7);
    vtap = 0.7;
    @(posedge clk); #1;
    start = 1'b0;
    check("post_hs_accept", busy, 1);
    wait_result(0.7, 0.7, "post_hs");
    @(posedge clk); #1;

    // Reset in the middle of a burst, then a clean burst afterwards.
    start_burst(4.0, 4.0);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_code", out_code, 0);
    check("midrst_vsrc", longint'(out_vsrc * 1e9), 0);
    check("midrst_clip", out_clip, 0);
    void'(sb.pop_back());
    #5;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_burst(2.0, 2.0);
    wait_result(2.0, 2.0, "after_rst");
    @(posedge clk); #1;

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
